// File: rtl/demux_nch_reg.sv
// demux_nch_reg: registered N-channel data demultiplexer for the synth voice bank.
// Routes an input word into per-channel holding registers with single, broadcast and
// auto-incrementing burst write modes, per-channel update strobes and an error flag
// for out-of-range selects.
// Optional feature macro: DEMUX_SLEW_EN -- writes update a per-channel target and the
// outputs slew toward it by at most SLEW_STEP per cycle.
`timescale 1ns/1ps

module demux_nch_reg #(
   parameter int W         = 8,
   parameter int N         = 24,
   parameter int SELW      = 5,
   parameter int BURST_LEN = 24,
   parameter int SLEW_STEP = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [W-1:0]      in,
   input  logic [SELW-1:0]   sel,
   input  logic              wr_en,
   input  logic              bcast,
   input  logic              burst_start,
   output logic [N*W-1:0]    out_bus,
   output logic [N-1:0]      upd,
   output logic              busy,
   output logic              err
);

   localparam int CNTW = $clog2(BURST_LEN + 1);

   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_t;

   // elaboration-time guard on the configuration
   if (N < 2 || N > 32 || (2 ** SELW) < N || BURST_LEN < 1 || BURST_LEN > N || SLEW_STEP < 1) begin : g_param_check
      $error("demux_nch_reg: illegal parameter combination");
   end

   state_t             r_state, w_state_nxt;
   logic [SELW-1:0]    r_ptr, w_ptr_nxt;
   logic [CNTW-1:0]    r_cnt, w_cnt_nxt;
   logic [N-1:0]       r_upd;
   logic               r_err;
   logic [W-1:0]       r_data [N];

   logic               w_sel_ok;
   logic [SELW-1:0]    w_sel_inc;
   logic [SELW-1:0]    w_ptr_inc;
   logic               w_wr_one;
   logic               w_wr_all;
   logic [SELW-1:0]    w_wr_idx;
   logic               w_err_nxt;
   logic [N-1:0]       w_wr_mask;

   assign w_sel_ok  = (32'(sel) < N);
   assign w_sel_inc = (32'(sel) == N - 1)   ? '0 : sel + SELW'(1);
   assign w_ptr_inc = (32'(r_ptr) == N - 1) ? '0 : r_ptr + SELW'(1);

   // next-state, burst pointer/counter and write-request decode
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_wr_one    = 1'b0;
      w_wr_all    = 1'b0;
      w_wr_idx    = sel;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (wr_en) begin
               if (burst_start && w_sel_ok) begin
                  w_wr_one    = 1'b1;
                  w_ptr_nxt   = w_sel_inc;
                  w_cnt_nxt   = CNTW'(1);
                  w_state_nxt = (BURST_LEN == 1) ? S_IDLE : S_BURST;
               end else if (bcast && !burst_start) begin
                  w_wr_all = 1'b1;
               end else if (w_sel_ok) begin
                  w_wr_one = 1'b1;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_BURST: begin
            if (wr_en) begin
               if (burst_start) begin
                  if (w_sel_ok) begin
                     w_wr_one    = 1'b1;
                     w_ptr_nxt   = w_sel_inc;
                     w_cnt_nxt   = CNTW'(1);
                     w_state_nxt = (BURST_LEN == 1) ? S_IDLE : S_BURST;
                  end else begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_wr_one  = 1'b1;
                  w_wr_idx  = r_ptr;
                  w_ptr_nxt = w_ptr_inc;
                  w_cnt_nxt = r_cnt + CNTW'(1);
                  if (w_cnt_nxt == CNTW'(BURST_LEN)) begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // one-hot (single/burst) or all-ones (broadcast) channel write mask
   always_comb begin
      w_wr_mask = '0;
      if (w_wr_all) begin
         w_wr_mask = '1;
      end else if (w_wr_one) begin
         w_wr_mask = N'(1) << w_wr_idx;
      end
   end

   // control state, update strobes and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_upd   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_upd   <= w_wr_mask;
         r_err   <= w_err_nxt;
      end
   end

`ifdef DEMUX_SLEW_EN
   logic [W-1:0] r_tgt  [N];
   logic [W-1:0] w_slew [N];

   // step each output toward its target, clamped so it never overshoots
   always_comb begin
      for (int unsigned c = 0; c < N; c++) begin
         w_slew[c] = r_data[c];
         if (r_tgt[c] > r_data[c]) begin
            w_slew[c] = ((r_tgt[c] - r_data[c]) > W'(SLEW_STEP)) ? r_data[c] + W'(SLEW_STEP) : r_tgt[c];
         end else if (r_tgt[c] < r_data[c]) begin
            w_slew[c] = ((r_data[c] - r_tgt[c]) > W'(SLEW_STEP)) ? r_data[c] - W'(SLEW_STEP) : r_tgt[c];
         end
      end
   end

   // writes land in the targets; outputs follow at the slew rate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < N; c++) begin
            r_tgt[c]  <= '0;
            r_data[c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < N; c++) begin
            if (w_wr_mask[c]) begin
               r_tgt[c] <= in;
            end
            r_data[c] <= w_slew[c];
         end
      end
   end
`else
   // channel holding registers, written directly by the mask
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < N; c++) begin
            r_data[c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < N; c++) begin
            if (w_wr_mask[c]) begin
               r_data[c] <= in;
            end
         end
      end
   end
`endif

   // flatten channel registers onto the output bus
   always_comb begin
      out_bus = '0;
      for (int unsigned c = 0; c < N; c++) begin
         out_bus[c*W +: W] = r_data[c];
      end
   end

   assign upd  = r_upd;
   assign err  = r_err;
   assign busy = (r_state == S_BURST);

endmodule
